// File: rtl/timer_pkg.sv
// Shared definitions for the elapsed-time controller.
//   timer_state_t : controller state encoding (IDLE, RUN, PAUSE, DONE)
//   TIMER_W       : default count/limit width
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_t;

  localparam int unsigned TIMER_W = 8;

endpackage

// File: rtl/tick_gen.sv
// Prescaler for the elapsed-time controller. Counts 0..PRESCALE-1 while
// enabled and flags a tick on the cycle the phase sits at PRESCALE-1.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset (phase -> 0)
//   en    : advance the phase this cycle
//   clr   : synchronous phase clear (wins over en)
//   tick  : high while en is set and the phase is at its last value
module tick_gen #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase;

  assign tick = en && (phase == LAST);

  // Phase is only held (never reset) when en drops, so a pause resumes
  // at the same point in the prescale period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= '0;
    end else if (clr || tick) begin
      phase <= '0;
    end else if (en) begin
      phase <= phase + PW'(1);
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Run/pause/clear controller for the elapsed-time counter.
// Commands (priority clear > stop > start) sequence an IDLE/RUN/PAUSE/DONE
// FSM; count advances on prescaled ticks and stops at the live limit.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   start, stop, clear: commands, sampled every cycle
//   limit             : terminal count (unsigned, live)
//   count             : elapsed count
//   running / done    : state is RUN / DONE
//   expired           : one-cycle pulse on entry to DONE
//   lap, lap_time     : count capture (only when TIMER_CTRL_LAP_EN is defined)
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH    = TIMER_W,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             done,
  output logic             expired
`ifdef TIMER_CTRL_LAP_EN
  ,
  input  logic             lap,
  output logic [WIDTH-1:0] lap_time
`endif
);

  timer_state_t     state_q, state_d;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH:0]   count_inc;
  logic             tick;
  logic             expired_d;

  // A stop or clear on a tick edge suppresses both the increment and the
  // prescaler advance.
  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .en   ((state_q == RUN) && !stop && !clear),
    .clr  (clear),
    .tick (tick)
  );

  assign count_inc = {1'b0, count} + (WIDTH + 1)'(1);

  always_comb begin
    state_d = state_q;
    count_d = count;
    if (clear) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!stop && start) begin
            state_d = (count >= limit) ? DONE : RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state_d = PAUSE;
          end else if (tick) begin
            count_d = count_inc[WIDTH-1:0];
            if (count_inc >= {1'b0, limit}) begin
              state_d = DONE;
            end
          end
        end
        PAUSE: begin
          if (!stop && start) begin
            state_d = RUN;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    expired_d = (state_d == DONE) && (state_q != DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count   <= '0;
      expired <= 1'b0;
    end else begin
      state_q <= state_d;
      count   <= count_d;
      expired <= expired_d;
    end
  end

  assign running = (state_q == RUN);
  assign done    = (state_q == DONE);

`ifdef TIMER_CTRL_LAP_EN
  // Captures the pre-increment count on the same edge as any tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lap_time <= '0;
    end else if (clear) begin
      lap_time <= '0;
    end else if (lap && ((state_q == RUN) || (state_q == PAUSE))) begin
      lap_time <= count;
    end
  end
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
`timescale 1ns/1ps
module tb_timer_ctrl;

  typedef struct packed {
    logic [7:0] count;
    logic       running;
    logic       done;
    logic       expired;
  } obs_t;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;

  logic       start1 = 1'b0, stop1 = 1'b0, clear1 = 1'b0;
  logic [7:0] limit1 = '0;
  logic [7:0] count1;
  logic       running1, done1, expired1;

  logic       start3 = 1'b0, stop3 = 1'b0, clear3 = 1'b0;
  logic [7:0] limit3 = '0;
  logic [7:0] count3;
  logic       running3, done3, expired3;

`ifdef TIMER_CTRL_LAP_EN
  logic       lap1 = 1'b0, lap3 = 1'b0;
  logic [7:0] lap_time1, lap_time3;
`endif

  obs_t o1, o3;
  assign o1 = {count1, running1, done1, expired1};
  assign o3 = {count3, running3, done3, expired3};

  obs_t       sb[$];
  logic [7:0] lsb[$];
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  timer_ctrl #(.WIDTH(8), .PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .stop(stop1), .clear(clear1),
    .limit(limit1), .count(count1), .running(running1), .done(done1),
    .expired(expired1)
`ifdef TIMER_CTRL_LAP_EN
    , .lap(lap1), .lap_time(lap_time1)
`endif
  );

  timer_ctrl #(.WIDTH(8), .PRESCALE(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .stop(stop3), .clear(clear3),
    .limit(limit3), .count(count3), .running(running3), .done(done3),
    .expired(expired3)
`ifdef TIMER_CTRL_LAP_EN
    , .lap(lap3), .lap_time(lap_time3)
`endif
  );

  task automatic test_reset();
    #12;
    checks++;
    if (o1 !== obs_t'(0)) begin
      errors++;
      $display("FAIL reset_p1: got count=%0d run=%b done=%b exp=%b, expected all 0", count1, running1, done1, expired1);
    end
    checks++;
    if (o3 !== obs_t'(0)) begin
      errors++;
      $display("FAIL reset_p3: got count=%0d run=%b done=%b exp=%b, expected all 0", count3, running3, done3, expired3);
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (o1 !== obs_t'(0)) begin
      errors++;
      $display("FAIL reset_release: got %h expected 000", o1);
    end
  endtask

  task automatic clear_dut1();
    obs_t e;
    clear1 = 1'b1; start1 = 1'b0; stop1 = 1'b0;
    sb.push_back(obs_t'(0));
    @(posedge clk); #1;
    clear1 = 1'b0;
    e = sb.pop_front();
    checks++;
    if (o1 !== e) begin
      errors++;
      $display("FAIL clear_p1: got count=%0d run=%b done=%b exp=%b, expected all 0", count1, running1, done1, expired1);
    end
  endtask

  task automatic clear_dut3();
    obs_t e;
    clear3 = 1'b1; start3 = 1'b0; stop3 = 1'b0;
    sb.push_back(obs_t'(0));
    @(posedge clk); #1;
    clear3 = 1'b0;
    e = sb.pop_front();
    checks++;
    if (o3 !== e) begin
      errors++;
      $display("FAIL clear_p3: got count=%0d run=%b done=%b exp=%b, expected all 0", count3, running3, done3, expired3);
    end
  endtask

  // P=1, limit=5: count 1..5 on successive edges, one expired pulse, done held.
  task automatic test_count_p1();
    obs_t e;
    limit1 = 8'd5;
    for (int i = 0; i < 8; i++) begin
      start1 = (i == 0);
      if (i < 5)       sb.push_back({8'(i), 1'b1, 1'b0, 1'b0});
      else if (i == 5) sb.push_back({8'd5, 1'b0, 1'b1, 1'b1});
      else             sb.push_back({8'd5, 1'b0, 1'b1, 1'b0});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (o1 !== e) begin
        errors++;
        $display("FAIL count_p1 cyc %0d: got count=%0d run=%b done=%b exp=%b, expected count=%0d run=%b done=%b exp=%b",
                 i, count1, running1, done1, expired1, e.count, e.running, e.done, e.expired);
      end
    end
    start1 = 1'b0;
    clear_dut1();
  endtask

  // P=3, limit=4: pause mid-phase for 10 cycles, resume from the held phase.
  task automatic test_pause_resume();
    obs_t e;
    logic [7:0] c;
    limit3 = 8'd4;
    for (int i = 0; i < 25; i++) begin
      start3 = (i == 0) || (i == 18);
      stop3  = (i >= 8) && (i <= 17);
      c = (i < 3) ? 8'd0 : (i < 6) ? 8'd1 : (i < 20) ? 8'd2 : (i < 23) ? 8'd3 : 8'd4;
      sb.push_back({c, (i < 8) || (i >= 18 && i < 23), i >= 23, i == 23});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (o3 !== e) begin
        errors++;
        $display("FAIL pause_resume cyc %0d: got count=%0d run=%b done=%b exp=%b, expected count=%0d run=%b done=%b exp=%b",
                 i, count3, running3, done3, expired3, e.count, e.running, e.done, e.expired);
      end
    end
    start3 = 1'b0; stop3 = 1'b0;
    clear_dut3();
  endtask

  task automatic test_limit_zero();
    obs_t e;
    limit1 = 8'd0;
    for (int i = 0; i < 3; i++) begin
      start1 = (i == 0);
      sb.push_back({8'd0, 1'b0, 1'b1, i == 0});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (o1 !== e) begin
        errors++;
        $display("FAIL limit_zero cyc %0d: got count=%0d run=%b done=%b exp=%b, expected count=0 run=0 done=1 exp=%b",
                 i, count1, running1, done1, expired1, e.expired);
      end
    end
    start1 = 1'b0;
    clear_dut1();
  endtask

  // All three commands at count=7, then start+stop and stop alone in IDLE.
  task automatic test_cmd_priority();
    obs_t e;
    limit1 = 8'd20;
    for (int i = 0; i < 13; i++) begin
      start1 = (i == 0) || (i == 8) || (i == 9) || (i == 11);
      stop1  = (i == 8) || (i == 9) || (i == 10);
      clear1 = (i == 8);
      if (i < 8)       sb.push_back({8'(i), 1'b1, 1'b0, 1'b0});
      else if (i < 11) sb.push_back(obs_t'(0));
      else             sb.push_back({8'(i - 11), 1'b1, 1'b0, 1'b0});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (o1 !== e) begin
        errors++;
        $display("FAIL cmd_priority cyc %0d: got count=%0d run=%b done=%b exp=%b, expected count=%0d run=%b done=%b exp=%b",
                 i, count1, running1, done1, expired1, e.count, e.running, e.done, e.expired);
      end
    end
    start1 = 1'b0; stop1 = 1'b0; clear1 = 1'b0;
    clear_dut1();
  endtask

  // limit lowered below count during RUN; start/stop then ignored in DONE.
  task automatic test_live_limit();
    obs_t e;
    for (int i = 0; i < 105; i++) begin
      limit1 = (i <= 100) ? 8'd200 : 8'd50;
      start1 = (i == 0) || (i == 102);
      stop1  = (i == 103);
      sb.push_back({(i <= 101) ? 8'(i) : 8'd101, i <= 100, i >= 101, i == 101});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (o1 !== e) begin
        errors++;
        $display("FAIL live_limit cyc %0d: got count=%0d run=%b done=%b exp=%b, expected count=%0d run=%b done=%b exp=%b",
                 i, count1, running1, done1, expired1, e.count, e.running, e.done, e.expired);
      end
    end
    start1 = 1'b0; stop1 = 1'b0;
    clear_dut1();
  endtask

  // Clear from PAUSE with the prescaler mid-phase must restart the phase at 0.
  task automatic test_clear_pause();
    obs_t e;
    logic [7:0] c;
    limit3 = 8'd9;
    for (int i = 0; i < 11; i++) begin
      start3 = (i == 0) || (i == 7);
      stop3  = (i == 5);
      clear3 = (i == 6);
      c = (i >= 3 && i <= 5) || (i == 10) ? 8'd1 : 8'd0;
      sb.push_back({c, (i <= 4) || (i >= 7), 1'b0, 1'b0});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (o3 !== e) begin
        errors++;
        $display("FAIL clear_pause cyc %0d: got count=%0d run=%b done=%b exp=%b, expected count=%0d run=%b done=%b exp=%b",
                 i, count3, running3, done3, expired3, e.count, e.running, e.done, e.expired);
      end
    end
    start3 = 1'b0; stop3 = 1'b0; clear3 = 1'b0;
    clear_dut3();
  endtask

  task automatic test_async_reset();
    obs_t e;
    limit1 = 8'd50;
    for (int i = 0; i < 5; i++) begin
      start1 = (i == 0);
      sb.push_back({8'(i), 1'b1, 1'b0, 1'b0});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (o1 !== e) begin
        errors++;
        $display("FAIL async_reset_run cyc %0d: got count=%0d run=%b, expected count=%0d run=1", i, count1, running1, e.count);
      end
    end
    #2 reset = 1'b0;
    start1 = 1'b1;
    #1;
    checks++;
    if (o1 !== obs_t'(0)) begin
      errors++;
      $display("FAIL async_reset_now: got count=%0d run=%b done=%b exp=%b, expected all 0", count1, running1, done1, expired1);
    end
    @(posedge clk); #1;
    checks++;
    if (o1 !== obs_t'(0)) begin
      errors++;
      $display("FAIL async_reset_held: got count=%0d run=%b, expected all 0", count1, running1);
    end
    @(negedge clk) reset = 1'b1;
    sb.push_back({8'd0, 1'b1, 1'b0, 1'b0});
    @(posedge clk); #1;
    start1 = 1'b0;
    e = sb.pop_front();
    checks++;
    if (o1 !== e) begin
      errors++;
      $display("FAIL async_reset_restart: got count=%0d run=%b, expected count=0 run=1", count1, running1);
    end
    clear_dut1();
  endtask

`ifdef TIMER_CTRL_LAP_EN
  task automatic test_lap();
    logic [7:0] e;
    limit1 = 8'd10;
    for (int i = 0; i < 14; i++) begin
      start1 = (i == 0);
      lap1   = (i == 4) || (i == 12);
      lsb.push_back((i < 4) ? 8'd0 : 8'd3);
      @(posedge clk); #1;
      e = lsb.pop_front();
      checks++;
      if (lap_time1 !== e) begin
        errors++;
        $display("FAIL lap_time cyc %0d: got %0d expected %0d", i, lap_time1, e);
      end
      if (i == 6) begin
        checks++;
        if (count1 !== 8'd6) begin
          errors++;
          $display("FAIL lap_count_continues: got %0d expected 6", count1);
        end
      end
    end
    start1 = 1'b0; lap1 = 1'b0;
    clear_dut1();
    checks++;
    if (lap_time1 !== 8'd0) begin
      errors++;
      $display("FAIL lap_clear: got %0d expected 0", lap_time1);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_count_p1();
    test_pause_resume();
    test_limit_zero();
    test_cmd_priority();
    test_live_limit();
    test_clear_pause();
    test_async_reset();
`ifdef TIMER_CTRL_LAP_EN
    test_lap();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
